// File: rtl/riscv_defines.sv
// Shared definitions for the program loader: FSM state type and size limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defines;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } loader_state_t;

  localparam int LOADER_MAX_WORDS = 1024;

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte-to-word packer: first accepted byte lands in bits 7:0.
// Latency: combinational word/done on the 4th accepted byte; partial bytes held in regs.
// Backpressure: none; bytes only advance on accept, so gaps simply hold the partial word.
// Ports: data (byte), accept (byte strobe), word (assembled word, valid with done),
//        done (high while the 4th byte of a word is being accepted).
module loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        done
);

  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      partial  <= 24'd0;
    end else if (accept) begin
      // 2-bit counter wraps 3->0 naturally at each word boundary
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    partial[7:0]   <= data;
        2'd1:    partial[15:8]  <= data;
        2'd2:    partial[23:16] <= data;
        default: ;
      endcase
    end
  end

  // The 4th byte is taken straight from the input; the consumer registers it.
  assign word = {data, partial};
  assign done = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: byte stream -> 32-bit word count header, then N words written to instruction memory.
// Latency: write strobe one cycle after a word's 4th byte; start one cycle after the last write.
// Backpressure: rx_ready high only while loading header/payload; dropped in RUN and ERR.
// Ports: clk, rst_n (async active-low); rx_valid/rx_data/rx_ready byte stream in;
//        prog_en/prog_addr/prog_data memory write out; start run release; load_err sticky error.
module prog_loader
  import riscv_defines::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = LOADER_MAX_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        prog_en,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        start,
  output logic        load_err
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam logic [WCW-1:0] ONE_W = 1;

  loader_state_t state, state_nxt;

  logic        acc;
  logic        hdr_acc, pay_acc;
  logic [31:0] hdr_word, pay_word;
  logic        hdr_done, pay_done;
  logic        hdr_bad;
  logic        last_word;

  logic [WCW-1:0] n_last;
  logic [WCW-1:0] word_idx;

  logic ready_nxt, start_nxt, err_nxt;

  assign acc     = rx_valid && rx_ready;
  assign hdr_acc = acc && (state == ST_HDR);
  assign pay_acc = acc && (state == ST_LOAD);

  loader_word_packer u_hdr_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (rx_data),
    .accept (hdr_acc),
    .word   (hdr_word),
    .done   (hdr_done)
  );

  loader_word_packer u_pay_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (rx_data),
    .accept (pay_acc),
    .word   (pay_word),
    .done   (pay_done)
  );

  assign hdr_bad   = (hdr_word == 32'd0) || (hdr_word > 32'(MAX_WORDS));
  assign last_word = (word_idx == n_last);

  // Word bookkeeping: the last index (N-1) is stored so the end test is a plain compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_last   <= '0;
      word_idx <= '0;
    end else if (hdr_done && !hdr_bad) begin
      n_last   <= WCW'(hdr_word - 32'd1);
      word_idx <= '0;
    end else if (pay_done) begin
      word_idx <= word_idx + ONE_W;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HDR;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR:  if (hdr_done) state_nxt = hdr_bad ? ST_ERR : ST_LOAD;
      ST_LOAD: if (pay_done && last_word) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_HDR;
    endcase
  end

  // Output decode. Flow-control and error follow the upcoming state so they change
  // on the same edge as the state; start follows the current state, which puts it
  // one cycle behind the final write strobe.
  always_comb begin
    ready_nxt = (state_nxt == ST_HDR) || (state_nxt == ST_LOAD);
    err_nxt   = (state_nxt == ST_ERR);
    start_nxt = (state == ST_RUN);
  end

  // Output registers: nothing from rx_* reaches an output without a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      prog_en   <= 1'b0;
      prog_addr <= 32'd0;
      prog_data <= 32'd0;
      start     <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rx_ready <= ready_nxt;
      prog_en  <= pay_done;
      if (pay_done) begin
        prog_addr <= BASE_ADDR + (32'(word_idx) << 2);
        prog_data <= pay_word;
      end
      start    <= start_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        rdy0, en0, start0, err0;
  logic [31:0] addr0, data0;
  logic        rdy1, en1, start1, err1;
  logic [31:0] addr1, data1;

  int checks = 0;
  int errors = 0;

  prog_loader dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy0), .prog_en(en0), .prog_addr(addr0), .prog_data(data0),
    .start(start0), .load_err(err0)
  );

  prog_loader #(.BASE_ADDR(32'h0000_0100)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy1), .prog_en(en1), .prog_addr(addr1), .prog_data(data1),
    .start(start1), .load_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stream is kept as a flat list of accepted bytes; every expectation is
  // derived from how many bytes have arrived and what the header says.
  localparam int MAXW = 1024;
  localparam int MBSZ = 4200;
  logic [7:0]  mb [0:MBSZ-1];
  int          nbytes;
  logic        m_ready, m_en, m_start, m_err;
  logic [31:0] m_addr, m_data;

  function automatic logic [31:0] hdr_n();
    return {mb[3], mb[2], mb[1], mb[0]};
  endfunction

  function automatic bit hdr_legal();
    return (nbytes >= 4) && (hdr_n() != 0) && (hdr_n() <= MAXW);
  endfunction

  function automatic bit load_done();
    return hdr_legal() && (nbytes == 4 + 4 * int'(hdr_n()));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit done_before, accepted;
    int k;
    if (!rst_n) begin
      nbytes = 0; m_ready = 0; m_en = 0; m_start = 0; m_err = 0;
      m_addr = 0; m_data = 0;
    end else begin
      done_before = load_done();
      accepted    = rx_valid && m_ready;
      if (accepted && nbytes < MBSZ) begin
        mb[nbytes] = rx_data;
        nbytes++;
      end
      m_en = accepted && hdr_legal() && (nbytes >= 8) && (nbytes % 4 == 0);
      if (m_en) begin
        k      = (nbytes - 8) / 4;
        m_addr = 32'(k * 4);
        m_data = {mb[nbytes-1], mb[nbytes-2], mb[nbytes-3], mb[nbytes-4]};
      end
      m_err   = (nbytes >= 4) && !hdr_legal();
      m_ready = !(m_err || load_done());
      m_start = done_before;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("rx_ready0", 32'(rdy0), 32'(m_ready));
    chk("prog_en0",  32'(en0),  32'(m_en));
    chk("start0",    32'(start0), 32'(m_start));
    chk("load_err0", 32'(err0), 32'(m_err));
    chk("rx_ready1", 32'(rdy1), 32'(m_ready));
    chk("prog_en1",  32'(en1),  32'(m_en));
    chk("start1",    32'(start1), 32'(m_start));
    chk("load_err1", 32'(err1), 32'(m_err));
    if (m_en) begin
      chk("prog_addr0", addr0, m_addr);
      chk("prog_data0", data0, m_data);
      chk("prog_addr1", addr1, m_addr + 32'h100);
      chk("prog_data1", data1, m_data);
    end
    if (!rst_n) begin
      chk("rst_addr0", addr0, 32'd0);
      chk("rst_data0", data0, 32'd0);
    end
  end

  // Write log for the hand-computed literal expectations.
  logic [31:0] wa[$], wd[$], wa1[$];
  always @(negedge clk) begin
    if (en0) begin
      wa.push_back(addr0);
      wd.push_back(data0);
    end
    if (en1) wa1.push_back(addr1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("async_rst_ready", 32'(rdy0), 32'd0);
    chk("async_rst_start", 32'(start0), 32'd0);
    chk("async_rst_err",   32'(err0), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    wa.delete(); wd.delete(); wa1.delete();
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(rdy0), 32'd1);
  endtask

  task automatic basic_checks(input string tag);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2 && wa1.size() == 2) begin
      chk({tag, "_a0"},  wa[0],  32'h0000_0000);
      chk({tag, "_d0"},  wd[0],  32'h0000_0013);
      chk({tag, "_a1"},  wa[1],  32'h0000_0004);
      chk({tag, "_d1"},  wd[1],  32'h0010_0093);
      chk({tag, "_b0"},  wa1[0], 32'h0000_0100);
      chk({tag, "_b1"},  wa1[1], 32'h0000_0104);
    end
    chk({tag, "_start"}, 32'(start0), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(rdy0), 32'd0);
    chk("reset_en",    32'(en0),  32'd0);
    chk("reset_start", 32'(start0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_ready", 32'(rdy0), 32'd1);

    // Basic back-to-back load of two words
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    idle(4);
    basic_checks("basic");

    // Bytes offered after release must be ignored
    for (int i = 0; i < 10; i++) send(8'($urandom), 0);
    idle(2);
    chk("postrun_ready",   32'(rdy0), 32'd0);
    chk("postrun_start",   32'(start0), 32'd1);
    chk("postrun_nwrites", 32'(wa.size()), 32'd2);

    // Same load with 3 idle cycles around every byte
    do_reset();
    send_word(32'd2, 3);
    send_word(32'h0000_0013, 3);
    send_word(32'h0010_0093, 3);
    idle(4);
    basic_checks("gapped");

    // N = 0 is illegal
    do_reset();
    send_word(32'd0, 0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 0);
    idle(2);
    chk("n0_err",     32'(err0), 32'd1);
    chk("n0_start",   32'(start0), 32'd0);
    chk("n0_ready",   32'(rdy0), 32'd0);
    chk("n0_nwrites", 32'(wa.size()), 32'd0);

    // N = MAX_WORDS + 1 is illegal
    do_reset();
    send_word(32'd1025, 0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 0);
    idle(2);
    chk("nmax1_err",   32'(err0), 32'd1);
    chk("nmax1_start", 32'(start0), 32'd0);
    chk("nmax1_ready", 32'(rdy0), 32'd0);

    // N = MAX_WORDS with incrementing data
    do_reset();
    send_word(32'd1024, 0);
    for (int k = 0; k < 1024; k++) send_word(32'(k), (k % 97 == 5) ? 2 : 0);
    idle(4);
    chk("nmax_nwrites", 32'(wa.size()), 32'd1024);
    if (wa.size() == 1024 && wa1.size() == 1024) begin
      chk("nmax_last_addr",  wa[1023],  32'h0000_0FFC);
      chk("nmax_last_data",  wd[1023],  32'd1023);
      chk("nmax_last_addr1", wa1[1023], 32'h0000_10FC);
    end
    chk("nmax_start", 32'(start0), 32'd1);
    chk("nmax_err",   32'(err0), 32'd0);

    // Reset in the middle of word 1, then a fresh single-word load
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1122_3344, 0);
    send(8'hAA, 0);
    send(8'hBB, 1);
    do_reset();
    send_word(32'd1, 0);
    send(8'hEF, 0);
    send(8'hBE, 0);
    send(8'hAD, 0);
    send(8'hDE, 0);
    idle(4);
    chk("midrst_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() == 1 && wa1.size() == 1) begin
      chk("midrst_addr",  wa[0],  32'h0000_0000);
      chk("midrst_data",  wd[0],  32'hDEAD_BEEF);
      chk("midrst_addr1", wa1[0], 32'h0000_0100);
    end
    chk("midrst_start", 32'(start0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
